// File: rtl/oldland_bus_arbiter.sv
// rtl/oldland_bus_arbiter.sv - two-requester memory port arbiter with data priority
// Anti-starvation streak counter and a per-transaction bus timeout.
module oldland_bus_arbiter #(
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_access,
  input  logic [29:0] i_addr,
  output logic [31:0] i_data,
  output logic        i_ack,
  output logic        i_error,
  input  logic        d_access,
  input  logic [29:0] d_addr,
  input  logic [3:0]  d_bytesel,
  input  logic        d_wr_en,
  input  logic [31:0] d_wr_val,
  output logic [31:0] d_data,
  output logic        d_ack,
  output logic        d_error,
  output logic        m_access,
  output logic [29:0] m_addr,
  output logic [3:0]  m_bytesel,
  output logic        m_wr_en,
  output logic [31:0] m_wr_val,
  input  logic [31:0] m_data,
  input  logic        m_ack,
  input  logic        m_error,
  output logic [1:0]  owner
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [1:0]  OWN_NONE = 2'b00;
  localparam logic [1:0]  OWN_I    = 2'b01;
  localparam logic [1:0]  OWN_D    = 2'b10;
  localparam logic [3:0]  STREAK_MAX = 4'(MAX_D_STREAK);
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam bit          TMO_EN     = (TIMEOUT_CYCLES != 0);

  state_t      state_q, state_d;
  logic        m_access_q, m_access_d;
  logic [29:0] m_addr_q, m_addr_d;
  logic [3:0]  m_bytesel_q, m_bytesel_d;
  logic        m_wr_en_q, m_wr_en_d;
  logic [31:0] m_wr_val_q, m_wr_val_d;
  logic [1:0]  owner_q, owner_d;
  logic [3:0]  streak_q, streak_d;
  logic [15:0] tmo_q, tmo_d;

  logic grant_i, grant_d, timed_out, done, err, ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      m_access_q  <= 1'b0;
      m_addr_q    <= '0;
      m_bytesel_q <= '0;
      m_wr_en_q   <= 1'b0;
      m_wr_val_q  <= '0;
      owner_q     <= OWN_NONE;
      streak_q    <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      m_access_q  <= m_access_d;
      m_addr_q    <= m_addr_d;
      m_bytesel_q <= m_bytesel_d;
      m_wr_en_q   <= m_wr_en_d;
      m_wr_val_q  <= m_wr_val_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    m_access_d  = m_access_q;
    m_addr_d    = m_addr_q;
    m_bytesel_d = m_bytesel_q;
    m_wr_en_d   = m_wr_en_q;
    m_wr_val_d  = m_wr_val_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    i_ack       = 1'b0;
    i_error     = 1'b0;
    d_ack       = 1'b0;
    d_error     = 1'b0;

    // D has priority unless it has already won MAX_D_STREAK times while I waited
    grant_i   = i_access && (!d_access || (streak_q == STREAK_MAX));
    grant_d   = d_access && !grant_i;
    timed_out = TMO_EN && (tmo_q == TMO_LAST) && !m_ack && !m_error;
    done      = m_ack || m_error || timed_out;
    err       = m_error || timed_out;
    ok        = m_ack && !err;

    case (state_q)
      IDLE: begin
        if (grant_i) begin
          m_addr_d    = i_addr;
          m_bytesel_d = 4'hF;
          m_wr_en_d   = 1'b0;
          m_wr_val_d  = '0;
          owner_d     = OWN_I;
          streak_d    = '0;
        end else if (grant_d) begin
          m_addr_d    = d_addr;
          m_bytesel_d = d_bytesel;
          m_wr_en_d   = d_wr_en;
          m_wr_val_d  = d_wr_val;
          owner_d     = OWN_D;
          if (i_access && streak_q != 4'hF) streak_d = streak_q + 4'd1;
        end
        if (grant_i || grant_d) begin
          m_access_d = 1'b1;
          tmo_d      = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        tmo_d   = tmo_q + 16'd1;
        i_ack   = (owner_q == OWN_I) && ok;
        i_error = (owner_q == OWN_I) && err;
        d_ack   = (owner_q == OWN_D) && ok;
        d_error = (owner_q == OWN_D) && err;
        if (done) begin
          m_access_d = 1'b0;
          owner_d    = OWN_NONE;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign i_data    = m_data;
  assign d_data    = m_data;
  assign m_access  = m_access_q;
  assign m_addr    = m_addr_q;
  assign m_bytesel = m_bytesel_q;
  assign m_wr_en   = m_wr_en_q;
  assign m_wr_val  = m_wr_val_q;
  assign owner     = owner_q;

endmodule
